// File: rtl/dt1_pkg.sv
// Shared types and constants for the dt1 pipeline hazard/sequencing controller.
package dt1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdState_t;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    // The M stage holds the younger write, so it takes precedence over W.
    function automatic logic [1:0] fwdSel(
        input logic       regWriteM,
        input logic [4:0] rdM,
        input logic       regWriteW,
        input logic [4:0] rdW,
        input logic [4:0] rs
    );
        if (regWriteM && (rdM != 5'd0) && (rdM == rs))
            return FWD_MEM;
        else if (regWriteW && (rdW != 5'd0) && (rdW == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/dt1_md_seq.sv
// Mul/div sequencer: start/done handshake with a BUSY-cycle watchdog and a sticky error flag.
module dt1_md_seq
    import dt1_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic MdReqE,
    input  logic MdDone,
    output logic MdStart,
    output logic MdBusy,
    output logic MdIdle,
    output logic MdErr
);

    mdState_t           state;
    mdState_t           nextState;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   countNext;
    logic               errSet;
    logic               startRaw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            MdErr <= 1'b0;
        end else begin
            state <= nextState;
            count <= countNext;
            MdErr <= MdErr | errSet;
        end
    end

    // DONE never starts a new op, so a request still held in E cannot retrigger.
    always_comb begin
        nextState = state;
        countNext = count;
        errSet    = 1'b0;
        startRaw  = 1'b0;
        unique case (state)
            IDLE: begin
                countNext = '0;
                if (MdReqE) begin
                    startRaw  = 1'b1;
                    nextState = BUSY;
                end
            end
            BUSY: begin
                if (MdDone) begin
                    nextState = DONE;
                end else if (count == CNT_W'(MD_TIMEOUT - 1)) begin
                    errSet    = 1'b1;
                    nextState = DONE;
                end else begin
                    countNext = count + CNT_W'(1);
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign MdStart = startRaw & ~rst;
    assign MdBusy  = (state == BUSY);
    assign MdIdle  = (state == IDLE);

endmodule

// File: rtl/dt1_pipe_ctrl.sv
// Central hazard controller for the 5-stage RV32I pipeline: forwarding, load-use, flush and mul/div stalls.
// Optional performance counters are enabled by defining DT1_PERF_CNT_EN.
module dt1_pipe_ctrl
    import dt1_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic       MdReqE,
    input  logic       MdDone,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MdStart,
    output logic       MdBusy,
    output logic       MdErr
`ifdef DT1_PERF_CNT_EN
    ,
    output logic [31:0] PerfLwStall,
    output logic [31:0] PerfMdStall,
    output logic [31:0] PerfFlush
`endif
);

    logic lwStall;
    logic mdIdle;
    logic lwStallEff;
    logic branchFlushEff;

    dt1_md_seq #(
        .MD_TIMEOUT (MD_TIMEOUT),
        .CNT_W      (CNT_W)
    ) uMdSeq (
        .clk     (clk),
        .rst     (rst),
        .MdReqE  (MdReqE),
        .MdDone  (MdDone),
        .MdStart (MdStart),
        .MdBusy  (MdBusy),
        .MdIdle  (mdIdle),
        .MdErr   (MdErr)
    );

    assign lwStall = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

    // Hazard responses only apply in IDLE; a taken branch overrides a load-use stall.
    assign branchFlushEff = ~rst & mdIdle & PCSrcE;
    assign lwStallEff     = ~rst & mdIdle & ~PCSrcE & lwStall;

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!rst) begin
            ForwardAE = fwdSel(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
            ForwardBE = fwdSel(RegWriteM, RdM, RegWriteW, RdW, Rs2E);
            if (MdBusy) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (branchFlushEff) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lwStallEff) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

`ifdef DT1_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            PerfLwStall <= '0;
            PerfMdStall <= '0;
            PerfFlush   <= '0;
        end else begin
            if (lwStallEff)     PerfLwStall <= PerfLwStall + 32'd1;
            if (MdBusy)         PerfMdStall <= PerfMdStall + 32'd1;
            if (branchFlushEff) PerfFlush   <= PerfFlush + 32'd1;
        end
    end
`endif

endmodule
